// File: rtl/dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : dmem_access_unit
// Brief    : Memory-stage data-memory controller. Turns a load/store into a
//            req/ack transaction on a variable-latency bus, formats byte/half/
//            word data, stalls the pipeline until the access completes and
//            flags misaligned accesses and bus timeouts.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_access_unit #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  m_valid,
  input  logic                  m_mem_read,
  input  logic                  m_dmem_we,
  input  logic [1:0]            m_size,
  input  logic                  m_unsigned,
  input  logic [31:0]           m_alu_out,
  input  logic [DATA_WIDTH-1:0] m_dmem_wd,
  output logic [DATA_WIDTH-1:0] m_dmem_rd,
  output logic                  stall,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [DATA_WIDTH-1:0] bus_wdata,
  output logic [3:0]            bus_be,
  input  logic                  bus_ack,
  input  logic [DATA_WIDTH-1:0] bus_rdata,
  output logic                  misalign_err,
  output logic                  timeout_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Timeout counter is 16 bits wide, enough for the full legal timeout range.
  localparam logic [15:0] c_timeout = 16'(TIMEOUT_CYCLES);

  state_t                  state_q, state_d;
  logic                    bus_req_q, bus_req_d;
  logic                    bus_we_q, bus_we_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [DATA_WIDTH-1:0]   bus_wdata_q, bus_wdata_d;
  logic [3:0]              bus_be_q, bus_be_d;
  logic [DATA_WIDTH-1:0]   m_dmem_rd_q, m_dmem_rd_d;
  logic                    misalign_err_q, misalign_err_d;
  logic                    timeout_err_q, timeout_err_d;
  logic [15:0]             tmo_cnt_q, tmo_cnt_d;
  // Access attributes latched at request time, used to format the read data.
  logic [1:0]              addr_lo_q, addr_lo_d;
  logic [1:0]              size_q, size_d;
  logic                    unsigned_q, unsigned_d;
  logic                    is_load_q, is_load_d;

  logic                    w_access;
  logic                    w_is_store;
  logic                    w_misaligned;
  logic [DATA_WIDTH-1:0]   w_wdata;
  logic [3:0]              w_be;
  logic [7:0]              w_byte_lane;
  logic [15:0]             w_half_lane;
  logic [DATA_WIDTH-1:0]   w_load_data;
  logic [15:0]             w_cnt_inc;
  logic                    w_stall;

  // A store wins when both read and write are flagged.
  assign w_access     = m_valid & (m_mem_read | m_dmem_we);
  assign w_is_store   = m_dmem_we;
  // Reserved size 2'b11 behaves as a word access (size[1] set).
  assign w_misaligned = ((m_size == 2'b01) & m_alu_out[0]) |
                        (m_size[1] & (m_alu_out[1:0] != 2'b00));
  assign w_cnt_inc    = tmo_cnt_q + 16'd1;

  // Place store data on the byte lanes and build byte enables for the access size.
  always_comb begin
    w_wdata = m_dmem_wd;
    w_be    = 4'b1111;
    case (m_size)
      2'b00: begin
        w_wdata = {4{m_dmem_wd[7:0]}};
        w_be    = 4'b0001 << m_alu_out[1:0];
      end
      2'b01: begin
        w_wdata = {2{m_dmem_wd[15:0]}};
        w_be    = m_alu_out[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        w_wdata = m_dmem_wd;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Select the addressed lane(s) of the read word and sign/zero-extend.
  always_comb begin
    w_byte_lane = bus_rdata[{addr_lo_q, 3'b000} +: 8];
    w_half_lane = addr_lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
    case (size_q)
      2'b00:   w_load_data = unsigned_q ? {24'd0, w_byte_lane}
                                        : {{24{w_byte_lane[7]}}, w_byte_lane};
      2'b01:   w_load_data = unsigned_q ? {16'd0, w_half_lane}
                                        : {{16{w_half_lane[15]}}, w_half_lane};
      default: w_load_data = bus_rdata;
    endcase
  end

  // Next-state logic for the IDLE -> REQ -> DONE access sequencer.
  always_comb begin
    state_d        = state_q;
    bus_req_d      = bus_req_q;
    bus_we_d       = bus_we_q;
    bus_addr_d     = bus_addr_q;
    bus_wdata_d    = bus_wdata_q;
    bus_be_d       = bus_be_q;
    m_dmem_rd_d    = m_dmem_rd_q;
    misalign_err_d = 1'b0;
    timeout_err_d  = 1'b0;
    tmo_cnt_d      = tmo_cnt_q;
    addr_lo_d      = addr_lo_q;
    size_d         = size_q;
    unsigned_d     = unsigned_q;
    is_load_d      = is_load_q;
    w_stall        = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (w_access) begin
          if (w_misaligned) begin
            // Rejected without touching the bus; the pipeline keeps moving.
            misalign_err_d = 1'b1;
            m_dmem_rd_d    = '0;
          end else begin
            w_stall     = 1'b1;
            state_d     = S_REQ;
            bus_req_d   = 1'b1;
            bus_we_d    = w_is_store;
            bus_addr_d  = ADDR_WIDTH'({m_alu_out[31:2], 2'b00});
            bus_wdata_d = w_wdata;
            bus_be_d    = w_be;
            tmo_cnt_d   = '0;
            addr_lo_d   = m_alu_out[1:0];
            size_d      = m_size;
            unsigned_d  = m_unsigned;
            is_load_d   = ~w_is_store;
          end
        end
      end
      S_REQ: begin
        w_stall = 1'b1;
        if (bus_ack) begin
          // An ack on the final allowed cycle still completes normally.
          bus_req_d = 1'b0;
          state_d   = S_DONE;
          if (is_load_q) begin
            m_dmem_rd_d = w_load_data;
          end
        end else if (w_cnt_inc == c_timeout) begin
          bus_req_d     = 1'b0;
          timeout_err_d = 1'b1;
          tmo_cnt_d     = w_cnt_inc;
          state_d       = S_DONE;
          if (is_load_q) begin
            m_dmem_rd_d = '0;
          end
        end else begin
          tmo_cnt_d = w_cnt_inc;
        end
      end
      S_DONE: begin
        // One non-stalled cycle lets the instruction leave; inputs ignored.
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and registered outputs; reset abandons any in-flight access.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= S_IDLE;
      bus_req_q      <= 1'b0;
      bus_we_q       <= 1'b0;
      bus_addr_q     <= '0;
      bus_wdata_q    <= '0;
      bus_be_q       <= 4'b0000;
      m_dmem_rd_q    <= '0;
      misalign_err_q <= 1'b0;
      timeout_err_q  <= 1'b0;
      tmo_cnt_q      <= '0;
      addr_lo_q      <= 2'b00;
      size_q         <= 2'b00;
      unsigned_q     <= 1'b0;
      is_load_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      bus_req_q      <= bus_req_d;
      bus_we_q       <= bus_we_d;
      bus_addr_q     <= bus_addr_d;
      bus_wdata_q    <= bus_wdata_d;
      bus_be_q       <= bus_be_d;
      m_dmem_rd_q    <= m_dmem_rd_d;
      misalign_err_q <= misalign_err_d;
      timeout_err_q  <= timeout_err_d;
      tmo_cnt_q      <= tmo_cnt_d;
      addr_lo_q      <= addr_lo_d;
      size_q         <= size_d;
      unsigned_q     <= unsigned_d;
      is_load_q      <= is_load_d;
    end
  end

  // Stall is forced low while reset is held so the pipeline is never frozen by reset.
  assign stall        = rstn & w_stall;
  assign bus_req      = bus_req_q;
  assign bus_we       = bus_we_q;
  assign bus_addr     = bus_addr_q;
  assign bus_wdata    = bus_wdata_q;
  assign bus_be       = bus_be_q;
  assign m_dmem_rd    = m_dmem_rd_q;
  assign misalign_err = misalign_err_q;
  assign timeout_err  = timeout_err_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_access_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_access_unit
// Brief    : Self-checking bench for dmem_access_unit: a table of accesses
//            with hand-derived expectations queued on a scoreboard, plus
//            hand-written reset and idle-ack sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_access_unit;

  localparam int TMO = 4;

  logic        clk;
  logic        rstn;
  logic        m_valid;
  logic        m_mem_read;
  logic        m_dmem_we;
  logic [1:0]  m_size;
  logic        m_unsigned;
  logic [31:0] m_alu_out;
  logic [31:0] m_dmem_wd;
  logic [31:0] m_dmem_rd;
  logic        stall;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        misalign_err;
  logic        timeout_err;

  dmem_access_unit #(
    .ADDR_WIDTH     (32),
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk          (clk),
    .rstn         (rstn),
    .m_valid      (m_valid),
    .m_mem_read   (m_mem_read),
    .m_dmem_we    (m_dmem_we),
    .m_size       (m_size),
    .m_unsigned   (m_unsigned),
    .m_alu_out    (m_alu_out),
    .m_dmem_wd    (m_dmem_wd),
    .m_dmem_rd    (m_dmem_rd),
    .stall        (stall),
    .bus_req      (bus_req),
    .bus_we       (bus_we),
    .bus_addr     (bus_addr),
    .bus_wdata    (bus_wdata),
    .bus_be       (bus_be),
    .bus_ack      (bus_ack),
    .bus_rdata    (bus_rdata),
    .misalign_err (misalign_err),
    .timeout_err  (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ld;
    logic        st;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] rdata;
    int          wait_n;     // wait cycles before ack; -1 = never ack
    int          exp_req;    // cycles bus_req is high
    int          exp_stall;  // cycles stall is high
    int          exp_mis;    // misalign_err pulses
    int          exp_to;     // timeout_err pulses
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;     // m_dmem_rd after the access
  } vec_t;

  vec_t vecs[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic vec_t mk(
    input logic ld, input logic st, input logic [1:0] size, input logic uns,
    input logic [31:0] addr, input logic [31:0] wd, input logic [31:0] rdata,
    input int wait_n, input int exp_req, input int exp_stall, input int exp_mis,
    input int exp_to, input logic exp_we, input logic [3:0] exp_be,
    input logic [31:0] exp_addr, input logic [31:0] exp_wdata, input logic [31:0] exp_rd);
    vec_t v;
    v.ld = ld; v.st = st; v.size = size; v.uns = uns;
    v.addr = addr; v.wd = wd; v.rdata = rdata; v.wait_n = wait_n;
    v.exp_req = exp_req; v.exp_stall = exp_stall; v.exp_mis = exp_mis;
    v.exp_to = exp_to; v.exp_we = exp_we; v.exp_be = exp_be;
    v.exp_addr = exp_addr; v.exp_wdata = exp_wdata; v.exp_rd = exp_rd;
    return v;
  endfunction

  task automatic check(input string what, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (case %0d): got 0x%08h, expected 0x%08h", what, id, act, exp);
    end
  endtask

  // Drive one access, observe it cycle by cycle at negedge, then compare
  // against the expectation popped from the scoreboard.
  task automatic run_vec(input vec_t v, input int id);
    int          req_cnt;
    int          stall_cnt;
    int          adv;
    int          mis_cnt;
    int          to_cnt;
    int          post;
    logic        consumed;
    logic        unstable;
    logic [31:0] o_addr;
    logic [31:0] o_wdata;
    logic [3:0]  o_be;
    logic        o_we;
    vec_t        e;
    req_cnt = 0; stall_cnt = 0; adv = 0; mis_cnt = 0; to_cnt = 0; post = 0;
    consumed = 1'b0; unstable = 1'b0;
    o_addr = '0; o_wdata = '0; o_be = '0; o_we = 1'b0;
    sb_q.push_back(v);
    @(negedge clk);
    m_valid    = 1'b1;
    m_mem_read = v.ld;
    m_dmem_we  = v.st;
    m_size     = v.size;
    m_unsigned = v.uns;
    m_alu_out  = v.addr;
    m_dmem_wd  = v.wd;
    bus_ack    = 1'b0;
    for (int t = 0; t < 64 && post < 4; t++) begin
      if (t > 0) begin
        @(negedge clk);
        if (consumed) m_valid = 1'b0;
      end
      #1;
      if (stall)        stall_cnt++;
      if (misalign_err) mis_cnt++;
      if (timeout_err)  to_cnt++;
      if (bus_req) begin
        if (req_cnt > 0 && (bus_addr !== o_addr || bus_be !== o_be ||
                            bus_we !== o_we || bus_wdata !== o_wdata))
          unstable = 1'b1;
        o_addr = bus_addr; o_be = bus_be; o_we = bus_we; o_wdata = bus_wdata;
        req_cnt++;
        if (v.wait_n >= 0 && req_cnt - 1 == v.wait_n) begin
          bus_ack   = 1'b1;
          bus_rdata = v.rdata;
        end else begin
          bus_ack   = 1'b0;
          bus_rdata = $urandom;
        end
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = $urandom;
      end
      if (m_valid && !stall) begin
        adv++;
        consumed = 1'b1;
      end
      if (consumed) post++;
    end
    m_valid = 1'b0;
    bus_ack = 1'b0;
    e = sb_q.pop_front();
    check("bus_req_cycles", id, req_cnt, e.exp_req);
    check("stall_cycles",   id, stall_cnt, e.exp_stall);
    check("advances",       id, adv, 1);
    check("misalign_pulses", id, mis_cnt, e.exp_mis);
    check("timeout_pulses", id, to_cnt, e.exp_to);
    check("m_dmem_rd",      id, m_dmem_rd, e.exp_rd);
    check("idle_after",     id, {30'd0, bus_req, stall}, 32'd0);
    if (e.exp_req > 0) begin
      check("bus_addr",   id, o_addr, e.exp_addr);
      check("bus_be",     id, {28'd0, o_be}, {28'd0, e.exp_be});
      check("bus_we",     id, {31'd0, o_we}, {31'd0, e.exp_we});
      check("bus_stable", id, {31'd0, unstable}, 32'd0);
      if (e.exp_we) check("bus_wdata", id, o_wdata, e.exp_wdata);
    end
  endtask

  // Absolute time limit so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd_hold;
    rstn = 1'b0; m_valid = 1'b0; m_mem_read = 1'b0; m_dmem_we = 1'b0;
    m_size = 2'b00; m_unsigned = 1'b0; m_alu_out = '0; m_dmem_wd = '0;
    bus_ack = 1'b0; bus_rdata = '0;

    //          ld st  sz    u  addr       wd           rdata        wt req stl mis to we be       addr         wdata         rd
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h100, 32'h0,        32'h89ABCDEF, 3, 4, 5, 0, 0, 0, 4'b1111, 32'h100, 32'h0,        32'h89ABCDEF));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h203, 32'h0,        32'h80FF1234, 0, 1, 2, 0, 0, 0, 4'b1000, 32'h200, 32'h0,        32'hFFFFFF80));
    vecs.push_back(mk(1, 0, 2'b00, 1, 32'h203, 32'h0,        32'h80FF1234, 1, 2, 3, 0, 0, 0, 4'b1000, 32'h200, 32'h0,        32'h00000080));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h0A2, 32'h0000BEEF, 32'h0,        0, 1, 2, 0, 0, 1, 4'b1100, 32'h0A0, 32'hBEEFBEEF, 32'h00000080));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h101, 32'h0,        32'h0,        0, 0, 0, 1, 0, 0, 4'b0000, 32'h0,   32'h0,        32'h00000000));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h102, 32'h0,        32'h80017FFF, 2, 3, 4, 0, 0, 0, 4'b1100, 32'h100, 32'h0,        32'hFFFF8001));
    vecs.push_back(mk(1, 0, 2'b01, 1, 32'h000, 32'h0,        32'h1234F00D, 0, 1, 2, 0, 0, 0, 4'b0011, 32'h000, 32'h0,        32'h0000F00D));
    vecs.push_back(mk(0, 1, 2'b00, 0, 32'h011, 32'h123456A5, 32'h0,        0, 1, 2, 0, 0, 1, 4'b0010, 32'h010, 32'hA5A5A5A5, 32'h0000F00D));
    vecs.push_back(mk(1, 0, 2'b10, 0, 32'h040, 32'h0,        32'h0,       -1, 4, 5, 0, 1, 0, 4'b1111, 32'h040, 32'h0,        32'h00000000));
    vecs.push_back(mk(0, 1, 2'b01, 0, 32'h003, 32'h11112222, 32'h0,        0, 0, 0, 1, 0, 0, 4'b0000, 32'h0,   32'h0,        32'h00000000));
    vecs.push_back(mk(0, 1, 2'b11, 0, 32'h00C, 32'hDEADBEEF, 32'h0,        0, 1, 2, 0, 0, 1, 4'b1111, 32'h00C, 32'hDEADBEEF, 32'h00000000));
    vecs.push_back(mk(1, 0, 2'b00, 0, 32'h001, 32'h0,        32'h00007F00, 0, 1, 2, 0, 0, 0, 4'b0010, 32'h000, 32'h0,        32'h0000007F));
    vecs.push_back(mk(1, 1, 2'b10, 0, 32'h020, 32'hCAFEF00D, 32'h0,        1, 2, 3, 0, 0, 1, 4'b1111, 32'h020, 32'hCAFEF00D, 32'h0000007F));
    vecs.push_back(mk(1, 0, 2'b10, 1, 32'h004, 32'h0,        32'hF0000001, 0, 1, 2, 0, 0, 0, 4'b1111, 32'h004, 32'h0,        32'hF0000001));
    vecs.push_back(mk(1, 0, 2'b11, 0, 32'h006, 32'h0,        32'h0,        0, 0, 0, 1, 0, 0, 4'b0000, 32'h0,   32'h0,        32'h00000000));
    vecs.push_back(mk(1, 0, 2'b01, 0, 32'h002, 32'h0,        32'h7FFF0000, 0, 1, 2, 0, 0, 0, 4'b1100, 32'h000, 32'h0,        32'h00007FFF));

    // Reset state, with an aligned load presented so stall gating is exercised.
    m_valid = 1'b1; m_mem_read = 1'b1; m_size = 2'b10; m_alu_out = 32'h100;
    repeat (3) @(negedge clk);
    #1;
    check("rst_stall",     0, {31'd0, stall}, 32'd0);
    check("rst_bus_req",   0, {31'd0, bus_req}, 32'd0);
    check("rst_bus_we",    0, {31'd0, bus_we}, 32'd0);
    check("rst_bus_addr",  0, bus_addr, 32'd0);
    check("rst_bus_wdata", 0, bus_wdata, 32'd0);
    check("rst_bus_be",    0, {28'd0, bus_be}, 32'd0);
    check("rst_m_dmem_rd", 0, m_dmem_rd, 32'd0);
    check("rst_errs",      0, {30'd0, misalign_err, timeout_err}, 32'd0);
    m_valid = 1'b0; m_mem_read = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i + 1);
    end

    // Acks with no access outstanding, and a valid non-memory instruction, are ignored.
    rd_hold = vecs[vecs.size() - 1].exp_rd;
    @(negedge clk);
    bus_ack = 1'b1; bus_rdata = 32'hFFFFFFFF;
    m_valid = 1'b1; m_mem_read = 1'b0; m_dmem_we = 1'b0; m_alu_out = 32'h0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_ack_req",   100, {31'd0, bus_req}, 32'd0);
    check("idle_ack_stall", 100, {31'd0, stall}, 32'd0);
    check("idle_ack_rd",    100, m_dmem_rd, rd_hold);
    bus_ack = 1'b0; m_valid = 1'b0;

    // Reset asserted while a load is waiting in REQ.
    @(negedge clk);
    m_valid = 1'b1; m_mem_read = 1'b1; m_dmem_we = 1'b0; m_size = 2'b10;
    m_unsigned = 1'b0; m_alu_out = 32'h300;
    @(negedge clk);
    #1;
    check("midreq_req_before", 101, {31'd0, bus_req}, 32'd1);
    #1;
    rstn = 1'b0;
    #1;
    check("midreq_req_drop",   101, {31'd0, bus_req}, 32'd0);
    check("midreq_stall_drop", 101, {31'd0, stall}, 32'd0);
    check("midreq_rd",         101, m_dmem_rd, 32'd0);
    @(negedge clk);
    m_valid = 1'b0; m_mem_read = 1'b0;
    rstn = 1'b1;
    run_vec(mk(1, 0, 2'b00, 1, 32'h302, 32'h0, 32'h00AB0000, 0, 1, 2, 0, 0, 0,
               4'b0100, 32'h300, 32'h0, 32'h000000AB), 102);

    check("scoreboard_empty", 103, sb_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
